// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the producer-side and FIFO-side signals of the write arbiter.
//   req        : per-requester "beat ready" flags
//   req_data   : per-requester data, requester i at [i*DW +: DW]
//   fifo_full  : FIFO full flag, combinational from the FIFO
//   gnt        : one-hot current owner (0 when idle)
//   ack        : per-requester beat-accepted strobe
//   fifo_wr    : FIFO write strobe
//   fifo_din   : FIFO write data
//   busy       : arbiter is in a burst
// master : environment side (producers + FIFO), slave : the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic               fifo_full;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic               fifo_wr;
    logic [DW-1:0]      fifo_din;
    logic               busy;

    modport master (
        output req, req_data, fifo_full,
        input  gnt, ack, fifo_wr, fifo_din, busy
    );

    modport slave (
        input  req, req_data, fifo_full,
        output gnt, ack, fifo_wr, fifo_din, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ producers.
// Each grant lasts up to BURST_LEN accepted beats; FIFO full stalls the burst.
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-low reset
//   bus  : fifo_wr_arbiter_if.slave (req/req_data/fifo_full in,
//          gnt/ack/fifo_wr/fifo_din/busy out)
module fifo_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 4,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(BURST_LEN + 1);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e            state_q;
    logic [IW-1:0]     owner_q;
    logic [IW-1:0]     last_owner_q;
    logic [CW-1:0]     beat_cnt_q;
    logic [NREQ-1:0]   gnt_q;
    logic              busy_q;

    logic              pick_valid;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     cand;
    logic              owner_req;
    logic [DW-1:0]     owner_data;
    logic              accept;
    logic              last_beat;

    // Round-robin search starting just after the last owner. Walking k downward
    // lets the nearest requester overwrite the farther ones.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((32'(last_owner_q) + 32'(k)) % NREQ);
            if (bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign owner_req  = bus.req[owner_q];
    assign owner_data = bus.req_data[32'(owner_q) * DW +: DW];
    assign accept     = (state_q == StBurst) && owner_req && !bus.fifo_full;
    assign last_beat  = (beat_cnt_q == CW'(BURST_LEN - 1));

    // Accept-path outputs are combinational so the beat lands in the same cycle
    // and are derived from reset-cleared state, so they drop with async reset.
    assign bus.fifo_wr  = accept;
    assign bus.fifo_din = accept ? owner_data : '0;
    assign bus.ack      = accept ? (NREQ'(1) << owner_q) : '0;
    assign bus.gnt      = gnt_q;
    assign bus.busy     = busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            last_owner_q <= IW'(NREQ - 1);
            beat_cnt_q   <= '0;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        state_q    <= StBurst;
                        owner_q    <= pick_idx;
                        gnt_q      <= NREQ'(1) << pick_idx;
                        beat_cnt_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                StBurst: begin
                    if (!owner_req) begin
                        // Early release: owner has nothing more to send.
                        state_q      <= StIdle;
                        gnt_q        <= '0;
                        busy_q       <= 1'b0;
                        last_owner_q <= owner_q;
                    end else if (!bus.fifo_full) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (last_beat) begin
                            state_q      <= StIdle;
                            gnt_q        <= '0;
                            busy_q       <= 1'b0;
                            last_owner_q <= owner_q;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
